pipeline_if_stage: RTL and testbench

PIPELINE_IF_STAGE -- requirements
Module: pipeline_if_stage

---
 rtl/pipeline_if_stage.sv | 70 +++++++
 tb/tb_pipeline_if_stage.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipeline_if_stage.sv
// pipeline_if_stage: instruction fetch unit with PC, IF/ID register, fetch counter and BOOT/RUN/HALT control.
module pipeline_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_data,
    input  logic        stall_signal,
    input  logic        branch_signal,
    input  logic [1:0]  pc_select,
    input  logic [31:0] branch_address,
    input  logic [31:0] jump_address,
    input  logic [31:0] register_address,
    output logic [31:0] npc_output,
    output logic [31:0] instruction,
    output logic [31:0] fetch_count,
    output logic        halted
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    state_t      state, state_next;
    logic [31:0] pc, pc_next, pc_plus4, npc_next, instr_next, count_next, target;
    logic        is_break;
    assign imem_address = pc;
    assign halted       = (state == HALT);
    assign pc_plus4     = pc + 32'd4;
    assign is_break     = (imem_data[31:26] == 6'b000000) && (imem_data[5:0] == 6'b001101);
    assign target       = pc_select == 2'b01 ? branch_address :
                          pc_select == 2'b10 ? jump_address :
                          pc_select == 2'b11 ? register_address : pc_plus4;
    always_comb begin
        state_next = state;
        pc_next    = pc;
        npc_next   = npc_output;
        instr_next = instruction;
        count_next = fetch_count;
        if (state == BOOT || state == HALT) begin
            state_next = (state == BOOT) ? RUN : HALT;
            npc_next   = '0;
            instr_next = NOP_WORD;
        end else if (!stall_signal && branch_signal) begin
            // a redirect flushes even a fetched break, so it never halts
            pc_next    = target;
            npc_next   = '0;
            instr_next = NOP_WORD;
        end else if (!stall_signal) begin
            pc_next    = pc_plus4;
            npc_next   = pc_plus4;
            instr_next = imem_data;
            count_next = fetch_count + 32'd1;
            state_next = is_break ? HALT : RUN;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            npc_output  <= '0;
            instruction <= NOP_WORD;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            npc_output  <= npc_next;
            instruction <= instr_next;
            fetch_count <= count_next;
        end
    end
endmodule

// File: tb/tb_pipeline_if_stage.sv
// tb_pipeline_if_stage: directed vector table plus randomized run against a rule-level fetch model.
module tb_pipeline_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0000;
    logic        clock = 1'b0, reset = 1'b0;
    logic [31:0] imem_address, imem_data = '0, branch_address = '0, jump_address = '0, register_address = '0;
    logic        stall_signal = 1'b0, branch_signal = 1'b0, halted;
    logic [1:0]  pc_select = 2'b00;
    logic [31:0] npc_output, instruction, fetch_count;
    int checks = 0, errors = 0;

    pipeline_if_stage dut (
        .clock(clock), .reset(reset), .imem_address(imem_address), .imem_data(imem_data),
        .stall_signal(stall_signal), .branch_signal(branch_signal), .pc_select(pc_select),
        .branch_address(branch_address), .jump_address(jump_address), .register_address(register_address),
        .npc_output(npc_output), .instruction(instruction), .fetch_count(fetch_count), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        stall, branch;
        logic [1:0]  sel;
        logic [31:0] ba, ja, ra, data, pc, ins, npc, cnt;
        logic        h;
    } vec_t;
    vec_t vecs[19];

    function automatic vec_t mk(input logic s, b, input logic [1:0] sel, input logic [31:0] ba, ja, ra, data,
                                pc, ins, npc, cnt, input logic h);
        vec_t v;
        v.stall = s; v.branch = b; v.sel = sel; v.ba = ba; v.ja = ja; v.ra = ra; v.data = data;
        v.pc = pc; v.ins = ins; v.npc = npc; v.cnt = cnt; v.h = h;
        return v;
    endfunction

    // Reference model: one instruction-level step per rising edge.
    logic        m_boot, m_halt;
    logic [31:0] m_pc, m_npc, m_ins, m_cnt;

    task automatic model_reset();
        m_boot = 1'b1; m_halt = 1'b0; m_pc = 32'h0; m_npc = 32'h0; m_ins = NOP; m_cnt = 32'h0;
    endtask

    task automatic model_step();
        if (m_boot || m_halt) begin
            m_boot = 1'b0; m_ins = NOP; m_npc = 32'h0;
        end else if (stall_signal) begin
        end else if (branch_signal) begin
            case (pc_select)
                2'd0: m_pc = m_pc + 32'd4;
                2'd1: m_pc = branch_address;
                2'd2: m_pc = jump_address;
                default: m_pc = register_address;
            endcase
            m_ins = NOP; m_npc = 32'h0;
        end else begin
            m_ins = imem_data; m_pc = m_pc + 32'd4; m_npc = m_pc; m_cnt = m_cnt + 32'd1;
            if (imem_data[31:26] == 6'd0 && imem_data[5:0] == 6'd13) m_halt = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, ins, npc, cnt, input logic h);
        check({tag, " pc"}, imem_address, pc);
        check({tag, " instruction"}, instruction, ins);
        check({tag, " npc"}, npc_output, npc);
        check({tag, " fetch_count"}, fetch_count, cnt);
        check({tag, " halted"}, {31'd0, halted}, {31'd0, h});
    endtask

    task automatic drive(input logic s, b, input logic [1:0] sel, input logic [31:0] ba, ja, ra, data);
        stall_signal = s; branch_signal = b; pc_select = sel;
        branch_address = ba; jump_address = ja; register_address = ra; imem_data = data;
    endtask

    // Asserts reset between edges and checks the outputs before any edge arrives.
    task automatic async_reset(input string tag);
        #2 reset = 1'b0;
        #1 check_all(tag, 32'h0, NOP, 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int halt_cycles;
        vecs[0]  = mk(0,0,0, 0,0,0, 32'h2008_0001,          32'h0,  NOP, 32'h0, 0, 0);
        vecs[1]  = mk(0,0,0, 0,0,0, 32'h2008_0001,          32'h4,  32'h2008_0001, 32'h4, 1, 0);
        vecs[2]  = mk(0,0,0, 0,0,0, 32'h11,                 32'h8,  32'h11, 32'h8, 2, 0);
        vecs[3]  = mk(0,1,1, 32'hC,32'h500,32'h600, 32'h99, 32'hC,  NOP, 32'h0, 2, 0);
        vecs[4]  = mk(0,0,0, 0,0,0, 32'h22,                 32'h10, 32'h22, 32'h10, 3, 0);
        for (int i = 5; i < 8; i++)
            vecs[i] = mk(1,1,1, 32'h80,32'h90,32'hA0, 32'h55, 32'h10, 32'h22, 32'h10, 3, 0);
        vecs[8]  = mk(0,1,1, 32'h40,32'h444,32'h888, 32'h55, 32'h40, NOP, 32'h0, 3, 0);
        vecs[9]  = mk(0,1,2, 32'h444,32'h80,32'h888, 32'h55, 32'h80, NOP, 32'h0, 3, 0);
        vecs[10] = mk(0,1,3, 32'h444,32'h888,32'hC0, 32'h55, 32'hC0, NOP, 32'h0, 3, 0);
        vecs[11] = mk(0,1,0, 32'h444,32'h888,32'h999, 32'h55, 32'hC4, NOP, 32'h0, 3, 0);
        vecs[12] = mk(0,1,3, 32'h444,32'h888,32'hFFFF_FFFC, 32'h55, 32'hFFFF_FFFC, NOP, 32'h0, 3, 0);
        vecs[13] = mk(0,0,0, 0,0,0, 32'h33,                 32'h0,  32'h33, 32'h0, 4, 0);
        vecs[14] = mk(0,1,1, 32'h20,32'h444,32'h888, 32'hD, 32'h20, NOP, 32'h0, 4, 0);
        vecs[15] = mk(0,0,0, 0,0,0, 32'hD,                  32'h24, 32'hD, 32'h24, 5, 1);
        vecs[16] = mk(1,1,3, 0,0,32'h100, 32'h77,           32'h24, NOP, 32'h0, 5, 1);
        vecs[17] = mk(0,1,3, 0,0,32'h100, 32'h77,           32'h24, NOP, 32'h0, 5, 1);
        vecs[18] = mk(0,0,0, 0,0,0, 32'h44,                 32'h24, NOP, 32'h0, 5, 1);

        #3 check_all("reset", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].branch, vecs[i].sel, vecs[i].ba, vecs[i].ja, vecs[i].ra, vecs[i].data);
            @(negedge clock);
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ins, vecs[i].npc, vecs[i].cnt, vecs[i].h);
        end
        async_reset("halt reset");

        // A few fetches, then reset between edges during RUN.
        drive(0,0,0, 0,0,0, 32'h1234_5678);
        repeat (4) @(negedge clock);
        check("run before reset count", fetch_count, 32'd3);
        async_reset("run reset");

        halt_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 29) == 0) ? {6'd0, 20'($urandom), 6'd13} : $urandom;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 2'($urandom),
                  $urandom, $urandom, $urandom, d);
            @(posedge clock);
            model_step();
            @(negedge clock);
            check_all("random", m_pc, m_ins, m_npc, m_cnt, m_halt);
            halt_cycles = m_halt ? halt_cycles + 1 : 0;
            if (halt_cycles > 4 || $urandom_range(0, 299) == 0) begin
                async_reset("random reset");
                halt_cycles = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
